pipe_hold_ctrl: RTL and testbench
=================================

// Module: pipe_hold_ctrl
// PURPOSE
//  Central pipeline sequencer. Merges stall/flush requests from ID, EX, the bus and the interrupt unit.
//  Drives per-stage hold flags (Pipe_Flow / Pipe_Hold / Pipe_Clear) to the if_id and id_ex stage registers.
//  Also drives PC hold/redirect to the fetch stage.
//  Owns the post-jump flush sequence, pending-jump capture and a stall watchdog.
// PARAMETERS
//  FLUSH_EXTRA  1    extra cycles if_id is cleared after a redirect (stale fetch drop); 0..7
//  STALL_MAX    255  consecutive PC-hold cycles before stall_timeout_o asserts; >=1
// PORTS
//  clk_i             in   1              clock
//  rst_i             in   1              asynchronous, active-high reset
//  jump_i            in   1              EX redirect request (branch/jal/trap)
//  jump_addr_i       in   InstAddrBus    redirect target
//  load_use_i        in   1              ID load-use hazard
//  ex_busy_i         in   1              EX multi-cycle op (div) in progress
//  bus_wait_i        in   1              LSU bus transaction not granted/complete
//  irq_hold_i        in   1              interrupt unit requests full hold
//  hold_if_id_o      out  Hold_Flag_Bus  flag to if_id register
//  hold_id_ex_o      out  Hold_Flag_Bus  flag to id_ex register
//  pc_hold_o         out  1              freeze PC
//  jump_o            out  1              load PC with jump_addr_o this cycle
//  jump_addr_o       out  InstAddrBus    PC redirect target
//  stall_timeout_o   out  1              watchdog flag
//  perf_stall_o      out  32             stall-cycle counter (macro-gated)
//  perf_flush_o      out  32             redirect counter (macro-gated)
// BEHAVIOUR
//  - While rst_i=1:
//    - both hold flags = Pipe_Clear.
//    - pc_hold_o, jump_o and stall_timeout_o = 0; jump_addr_o = 0.
//    - FSM = RUN; counters and the pending-jump register = 0.
//  - Per-cycle decision is combinational on inputs + state, in strict priority (first match wins):
//    1. bus_wait_i | irq_hold_i: if_id=Hold, id_ex=Hold, pc_hold=1, jump_o=0.
//       - If jump_i=1 in the same cycle: capture jump_addr_i into pend_addr, set pend=1.
//    2. jump_i | pend: if_id=Clear, id_ex=Clear, jump_o=1, pc_hold=0.
//       - jump_addr_o = pend ? pend_addr : jump_addr_i; clear pend.
//       - Next state FLUSH with fcnt=FLUSH_EXTRA; if FLUSH_EXTRA=0 stay RUN.
//    3. ex_busy_i: if_id=Hold, id_ex=Hold, pc_hold=1.
//    4. load_use_i: if_id=Hold, id_ex=Clear (bubble), pc_hold=1.
//    5. state FLUSH: if_id=Clear, id_ex=Flow, pc_hold=0.
//       - fcnt decrements each cycle; state returns to RUN after the cycle with fcnt=1.
//    6. otherwise: Flow/Flow, pc_hold=0.
//  - FSM states RUN, FLUSH.
//    - A rule-1 hold while in FLUSH freezes fcnt.
//    - A new redirect while in FLUSH reloads fcnt = FLUSH_EXTRA.
//    - A second jump_i while pend=1 and hold persists overwrites pend_addr (newest wins).
//  - jump_addr_o = 0 whenever jump_o = 0.
//  - Watchdog: scnt increments on every cycle with pc_hold_o=1 and saturates at STALL_MAX.
//    - Clears to 0 on the first cycle with pc_hold_o=0.
//    - stall_timeout_o = (scnt == STALL_MAX), registered; stays high until the stall releases.
//    - scnt width = $clog2(STALL_MAX+1).
//  - Reset asserted mid-stall or mid-flush drops pend and the flush sequence; no redirect is replayed.
// CONFIGURATION
//  - PIPE_CTRL_PERF_EN defined:
//    - perf_stall_o increments every cycle pc_hold_o=1.
//    - perf_flush_o increments on every cycle jump_o=1.
//    - Both are 32-bit, wrap 0xFFFF_FFFF->0, reset to 0.
//  - Macro undefined: both ports are tied to 0 and no counter flops are built.
// TESTING
//  1. jump_i=1, jump_addr_i=0x100, FLUSH_EXTRA=1:
//     -> cycle0 Clear/Clear, jump_o=1, addr 0x100.
//     -> cycle1 Clear/Flow.
//     -> cycle2 Flow/Flow.
//  2. load_use_i for 1 cycle -> if_id=Hold, id_ex=Clear, pc_hold=1; next cycle Flow/Flow.
//  3. ex_busy_i for 34 cycles -> Hold/Hold, pc_hold=1 for exactly 34 cycles.
//     - perf_stall_o += 34 with PIPE_CTRL_PERF_EN.
//  4. bus_wait_i=1 for 3 cycles, jump_i=1 (0x200) in cycle 1 only:
//     -> hold for 3 cycles.
//     -> cycle 3: jump_o=1, addr 0x200, Clear/Clear.
//  5. STALL_MAX=4, bus_wait_i high 10 cycles:
//     -> stall_timeout_o rises after 4 held cycles and stays high.
//     -> drops the cycle after bus_wait_i falls.
//  6. rst_i pulse during FLUSH with pend=1 -> Clear/Clear while in reset.
//     -> Flow/Flow after release; jump_o never asserts.

Source files
------------

// File: rtl/pipe_hold_ctrl_if.sv
// Request/flag bundle between the pipeline sequencer and its clients.
// slave: sequencer side (takes requests, drives flags); master: client side.
interface pipe_hold_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              jump_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              load_use_i;
  logic              ex_busy_i;
  logic              bus_wait_i;
  logic              irq_hold_i;
  logic [1:0]        hold_if_id_o;
  logic [1:0]        hold_id_ex_o;
  logic              pc_hold_o;
  logic              jump_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              stall_timeout_o;
  logic [31:0]       perf_stall_o;
  logic [31:0]       perf_flush_o;

  modport slave (
    input  jump_i, jump_addr_i,
    input  load_use_i, ex_busy_i,
    input  bus_wait_i, irq_hold_i,
    output hold_if_id_o, hold_id_ex_o,
    output pc_hold_o, jump_o, jump_addr_o,
    output stall_timeout_o,
    output perf_stall_o, perf_flush_o
  );

  modport master (
    output jump_i, jump_addr_i,
    output load_use_i, ex_busy_i,
    output bus_wait_i, irq_hold_i,
    input  hold_if_id_o, hold_id_ex_o,
    input  pc_hold_o, jump_o, jump_addr_o,
    input  stall_timeout_o,
    input  perf_stall_o, perf_flush_o
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline sequencer: merges stall/flush requests into if_id/id_ex hold
// flags and PC hold/redirect; owns post-jump flush, pending jump, watchdog.
// Ports: clk_i, rst_i (async, active-high), bus (pipe_hold_ctrl_if.slave).
// Flags: 0=Flow 1=Hold 2=Clear. Macro PIPE_CTRL_PERF_EN adds perf counters.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_EXTRA = 1,
  parameter int unsigned STALL_MAX   = 255,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  pipe_hold_ctrl_if.slave bus
);

  localparam logic [1:0] PIPE_FLOW  = 2'd0;
  localparam logic [1:0] PIPE_HOLD  = 2'd1;
  localparam logic [1:0] PIPE_CLEAR = 2'd2;

  localparam int unsigned SCNT_W = $clog2(STALL_MAX + 1);
  localparam logic [SCNT_W-1:0] SMAX = SCNT_W'(STALL_MAX);
  localparam logic [2:0] FX = 3'(FLUSH_EXTRA);

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              tout_q;

  logic [1:0]        ifid, idex;
  logic              pc_hold, jump;
  logic [ADDR_W-1:0] jaddr;

  always_comb begin
    ifid    = PIPE_FLOW;
    idex    = PIPE_FLOW;
    pc_hold = 1'b0;
    jump    = 1'b0;
    jaddr   = '0;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    paddr_d = paddr_q;
    if (rst_i) begin
      ifid = PIPE_CLEAR;
      idex = PIPE_CLEAR;
    end else if (bus.bus_wait_i || bus.irq_hold_i) begin
      // full freeze; a redirect seen now is parked until release
      ifid    = PIPE_HOLD;
      idex    = PIPE_HOLD;
      pc_hold = 1'b1;
      if (bus.jump_i) begin
        pend_d  = 1'b1;
        paddr_d = bus.jump_addr_i;
      end
    end else if (bus.jump_i || pend_q) begin
      ifid   = PIPE_CLEAR;
      idex   = PIPE_CLEAR;
      jump   = 1'b1;
      jaddr  = pend_q ? paddr_q : bus.jump_addr_i;
      pend_d = 1'b0;
      if (FLUSH_EXTRA == 0) begin
        state_d = RUN;
        fcnt_d  = '0;
      end else begin
        state_d = FLUSH;
        fcnt_d  = FX;
      end
    end else if (bus.ex_busy_i) begin
      ifid    = PIPE_HOLD;
      idex    = PIPE_HOLD;
      pc_hold = 1'b1;
    end else if (bus.load_use_i) begin
      ifid    = PIPE_HOLD;
      idex    = PIPE_CLEAR;
      pc_hold = 1'b1;
    end else if (state_q == FLUSH) begin
      // drop the stale fetch still arriving behind the redirect
      ifid   = PIPE_CLEAR;
      idex   = PIPE_FLOW;
      fcnt_d = fcnt_q - 3'd1;
      if (fcnt_q <= 3'd1) begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    end
  end

  always_comb begin
    scnt_d = '0;
    if (pc_hold) begin
      scnt_d = (scnt_q == SMAX) ? scnt_q : scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      scnt_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      scnt_q  <= scnt_d;
      tout_q  <= (scnt_d == SMAX);
    end
  end

  assign bus.hold_if_id_o    = ifid;
  assign bus.hold_id_ex_o    = idex;
  assign bus.pc_hold_o       = pc_hold;
  assign bus.jump_o          = jump;
  assign bus.jump_addr_o     = jaddr;
  assign bus.stall_timeout_o = tout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pstall_q;
  logic [31:0] pflush_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pstall_q <= '0;
      pflush_q <= '0;
    end else begin
      pstall_q <= pstall_q + {31'd0, pc_hold};
      pflush_q <= pflush_q + {31'd0, jump};
    end
  end

  assign bus.perf_stall_o = pstall_q;
  assign bus.perf_flush_o = pflush_q;
`else
  assign bus.perf_stall_o = '0;
  assign bus.perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed scoreboard bench for pipe_hold_ctrl.
// Driver queues hand-computed per-cycle expectations; monitor compares.
module tb_pipe_hold_ctrl;

  localparam logic [1:0] F = 2'd0;
  localparam logic [1:0] H = 2'd1;
  localparam logic [1:0] C = 2'd2;

  typedef struct {
    string       nm;
    logic [1:0]  ifid;
    logic [1:0]  idex;
    logic        pch;
    logic        jmp;
    logic [31:0] addr;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_pst = 0;
  int   exp_pfl = 0;

  pipe_hold_ctrl_if #(.ADDR_W(32)) bif ();

  pipe_hold_ctrl #(
    .FLUSH_EXTRA(1),
    .STALL_MAX(4),
    .ADDR_W(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bif.hold_if_id_o !== e.ifid || bif.hold_id_ex_o !== e.idex ||
          bif.pc_hold_o !== e.pch || bif.jump_o !== e.jmp ||
          bif.jump_addr_o !== e.addr || bif.stall_timeout_o !== e.to) begin
        errors++;
        $display("FAIL %s: got if_id=%0d id_ex=%0d pch=%0b jmp=%0b addr=%h to=%0b exp if_id=%0d id_ex=%0d pch=%0b jmp=%0b addr=%h to=%0b",
                 e.nm, bif.hold_if_id_o, bif.hold_id_ex_o, bif.pc_hold_o,
                 bif.jump_o, bif.jump_addr_o, bif.stall_timeout_o,
                 e.ifid, e.idex, e.pch, e.jmp, e.addr, e.to);
      end
    end
  end

  task automatic step(
    input string       nm,
    input logic        r,
    input logic        j,
    input logic [31:0] ja,
    input logic        lu, eb, bw, ih,
    input logic [1:0]  ei, ee,
    input logic        ep, ej,
    input logic [31:0] ea,
    input logic        et
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bif.jump_i      = j;
    bif.jump_addr_i = ja;
    bif.load_use_i  = lu;
    bif.ex_busy_i   = eb;
    bif.bus_wait_i  = bw;
    bif.irq_hold_i  = ih;
    e.nm = nm; e.ifid = ei; e.idex = ee; e.pch = ep;
    e.jmp = ej; e.addr = ea; e.to = et;
    q.push_back(e);
    if (r) begin
      exp_pst = 0;
      exp_pfl = 0;
    end else begin
      exp_pst += int'(ep);
      exp_pfl += int'(ej);
    end
  endtask

  task automatic idle(input string nm, input logic [1:0] ei, input logic et);
    step(nm, 0, 0, 0, 0, 0, 0, 0, ei, F, 0, 0, 0, et);
  endtask

  initial begin
    bif.jump_i      = 1'b0;
    bif.jump_addr_i = '0;
    bif.load_use_i  = 1'b0;
    bif.ex_busy_i   = 1'b0;
    bif.bus_wait_i  = 1'b0;
    bif.irq_hold_i  = 1'b0;

    step("reset0", 1, 0, 0, 0, 0, 0, 0, C, C, 0, 0, 0, 0);
    step("reset1", 1, 1, 32'h44, 0, 0, 1, 0, C, C, 0, 0, 0, 0);
    idle("idle", F, 0);

    step("jmp_c0", 0, 1, 32'h100, 0, 0, 0, 0, C, C, 0, 1, 32'h100, 0);
    idle("jmp_c1", C, 0);
    idle("jmp_c2", F, 0);

    step("lduse", 0, 0, 0, 1, 0, 0, 0, H, C, 1, 0, 0, 0);
    idle("lduse_after", F, 0);

    for (int k = 0; k < 34; k++)
      step("exbusy", 0, 0, 0, 0, 1, 0, 0, H, H, 1, 0, 0, k >= 4);
    idle("exbusy_rel", F, 1);
    idle("exbusy_rel2", F, 0);

    step("bw0", 0, 0, 0, 0, 0, 1, 0, H, H, 1, 0, 0, 0);
    step("bw1_jmp", 0, 1, 32'h200, 0, 0, 1, 0, H, H, 1, 0, 0, 0);
    step("bw2", 0, 0, 0, 0, 0, 1, 0, H, H, 1, 0, 0, 0);
    idle("pend_jmp", C, 0);
    q[$].idex = C; q[$].jmp = 1; q[$].addr = 32'h200;
    idle("pend_fl", C, 0);
    idle("pend_run", F, 0);

    step("nw0", 0, 1, 32'h300, 0, 0, 1, 0, H, H, 1, 0, 0, 0);
    step("nw1", 0, 1, 32'h340, 0, 0, 1, 0, H, H, 1, 0, 0, 0);
    step("nw2", 0, 0, 0, 0, 0, 1, 0, H, H, 1, 0, 0, 0);
    step("nw_jmp", 0, 0, 32'h999, 0, 0, 0, 0, C, C, 0, 1, 32'h340, 0);
    idle("nw_fl", C, 0);
    idle("nw_run", F, 0);

    for (int k = 0; k < 10; k++)
      step("wdog", 0, 0, 0, 0, 0, 1, 0, H, H, 1, 0, 0, k >= 4);
    idle("wdog_rel", F, 1);
    idle("wdog_rel2", F, 0);

    step("irq", 0, 0, 0, 0, 0, 0, 1, H, H, 1, 0, 0, 0);
    idle("irq_rel", F, 0);

    step("frz_jmp", 0, 1, 32'h400, 0, 0, 0, 0, C, C, 0, 1, 32'h400, 0);
    step("frz_h0", 0, 0, 0, 0, 0, 0, 1, H, H, 1, 0, 0, 0);
    step("frz_h1", 0, 0, 0, 0, 0, 0, 1, H, H, 1, 0, 0, 0);
    idle("frz_fl", C, 0);
    idle("frz_run", F, 0);

    step("rl_jmp", 0, 1, 32'h410, 0, 0, 0, 0, C, C, 0, 1, 32'h410, 0);
    step("rl_jmp2", 0, 1, 32'h420, 0, 0, 0, 0, C, C, 0, 1, 32'h420, 0);
    idle("rl_fl", C, 0);
    idle("rl_run", F, 0);

    step("prio_j_lu", 0, 1, 32'h480, 1, 0, 0, 0, C, C, 0, 1, 32'h480, 0);
    idle("prio_fl", C, 0);
    step("prio_eb_lu", 0, 0, 0, 1, 1, 0, 0, H, H, 1, 0, 0, 0);
    idle("prio_run", F, 0);

    step("r6_jmp", 0, 1, 32'h500, 0, 0, 0, 0, C, C, 0, 1, 32'h500, 0);
    step("r6_pend", 0, 1, 32'h600, 0, 0, 1, 0, H, H, 1, 0, 0, 0);
    step("r6_rst0", 1, 0, 0, 0, 0, 1, 0, C, C, 0, 0, 0, 0);
    step("r6_rst1", 1, 0, 0, 0, 0, 0, 0, C, C, 0, 0, 0, 0);
    idle("r6_rel0", F, 0);
    idle("r6_rel1", F, 0);
    idle("r6_rel2", F, 0);
    step("r6_lu", 0, 0, 0, 1, 0, 0, 0, H, C, 1, 0, 0, 0);
    step("r6_jmp2", 0, 1, 32'h700, 0, 0, 0, 0, C, C, 0, 1, 32'h700, 0);
    idle("r6_fl", C, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (bif.perf_stall_o !== 32'(exp_pst)) begin
      errors++;
      $display("FAIL perf_stall: got %0d exp %0d", bif.perf_stall_o, exp_pst);
    end
    checks++;
    if (bif.perf_flush_o !== 32'(exp_pfl)) begin
      errors++;
      $display("FAIL perf_flush: got %0d exp %0d", bif.perf_flush_o, exp_pfl);
    end
`else
    checks++;
    if (bif.perf_stall_o !== 32'd0 || bif.perf_flush_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_tied: got %0d/%0d exp 0/0",
               bif.perf_stall_o, bif.perf_flush_o);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
